// File: rtl/card_pkg.sv
// Shared card-dealer types: deck geometry, suit/rank encodings, dealer FSM states
// and the blackjack point-value helper.
package card_pkg;
   localparam int DECK_SIZE = 52;
   localparam int SUIT_SIZE = 13;

   typedef enum logic [1:0] {CLUBS, DIAMONDS, HEARTS, SPADES} suit_t;
   typedef logic [3:0] rank_t;
   typedef enum logic [2:0] {IDLE, REQUEST, SAMPLE, PROBE, DONE, EMPTY} dealer_state_t;

   // Face cards all count 10; ace counts 1 here, the hand logic decides on 11.
   function automatic logic [3:0] card_points_f(input rank_t rank);
      return (rank >= 4'd10) ? 4'd10 : rank;
   endfunction
endpackage

// File: rtl/card_decode.sv
// Combinational card index (0..51) -> rank (1..13), suit, blackjack points.
// Shared with the hand-display logic.
module card_decode
   import card_pkg::*;
(
   input  logic [5:0] idx,
   output logic [3:0] rank,
   output logic [1:0] suit,
   output logic [3:0] points
);
   suit_t     s;
   logic [3:0] off;

   // Compare chain instead of a divider: only four suit bands to test.
   always_comb begin
      if (idx >= 6'(3*SUIT_SIZE)) begin
         s   = SPADES;
         off = 4'(idx - 6'(3*SUIT_SIZE));
      end else if (idx >= 6'(2*SUIT_SIZE)) begin
         s   = HEARTS;
         off = 4'(idx - 6'(2*SUIT_SIZE));
      end else if (idx >= 6'(SUIT_SIZE)) begin
         s   = DIAMONDS;
         off = 4'(idx - 6'(SUIT_SIZE));
      end else begin
         s   = CLUBS;
         off = idx[3:0];
      end
   end

   assign rank   = off + 4'd1;
   assign suit   = s;
   assign points = card_points_f(rank);
endmodule

// File: rtl/card_dealer.sv
// Deals cards without replacement: requests a random value, then linearly probes
// the used-card mask (wrapping at the top) for the first free card.
module card_dealer #(
   parameter int DECK_SIZE = 52,
   parameter int RNG_WIDTH = 6
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 shuffle,
   input  logic                 deal_req,
   input  logic [RNG_WIDTH-1:0] rng_value,
   output logic                 rng_request,
   output logic [RNG_WIDTH-1:0] rng_max,
   output logic                 card_valid,
   output logic [3:0]           card_rank,
   output logic [1:0]           card_suit,
   output logic [3:0]           card_points,
   output logic                 busy,
   output logic                 deck_empty,
   output logic [5:0]           cards_left
);
   import card_pkg::*;

   dealer_state_t        state, state_nx;
   logic [DECK_SIZE-1:0] used;
   logic [RNG_WIDTH-1:0] p;
   logic                 shuf_pend;
   logic                 clear;
   logic [3:0]           dec_rank, dec_points;
   logic [1:0]           dec_suit;

   card_decode u_decode (
      .idx    (6'(p)),
      .rank   (dec_rank),
      .suit   (dec_suit),
      .points (dec_points)
   );

   assign rng_request = (state == REQUEST);
   assign card_valid  = (state == DONE);
   assign busy        = (state != IDLE) && (state != EMPTY);
   assign deck_empty  = (cards_left == 6'd0);
   assign rng_max     = RNG_WIDTH'(DECK_SIZE-1);

   // A shuffle seen mid-deal is deferred so the in-flight card still counts
   // against the old deck; it is applied on the DONE -> IDLE transition.
   always_comb begin
      state_nx = state;
      clear    = 1'b0;
      case (state)
         IDLE: begin
            if (shuffle)
               clear = 1'b1;
            else if (deal_req)
               state_nx = (cards_left == 6'd0) ? EMPTY : REQUEST;
         end
         REQUEST: state_nx = SAMPLE;
         SAMPLE:  state_nx = PROBE;
         PROBE:   if (!used[p]) state_nx = DONE;
         DONE: begin
            if (shuffle || shuf_pend) begin
               clear    = 1'b1;
               state_nx = IDLE;
            end else begin
               state_nx = (cards_left == 6'd0) ? EMPTY : IDLE;
            end
         end
         EMPTY: begin
            if (shuffle) begin
               clear    = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         used        <= '0;
         cards_left  <= 6'(DECK_SIZE);
         p           <= '0;
         shuf_pend   <= 1'b0;
         card_rank   <= 4'd0;
         card_suit   <= 2'd0;
         card_points <= 4'd0;
      end else begin
         state <= state_nx;
         if (clear) begin
            used       <= '0;
            cards_left <= 6'(DECK_SIZE);
            shuf_pend  <= 1'b0;
         end else if (shuffle && busy) begin
            shuf_pend <= 1'b1;
         end
         case (state)
            // Out-of-range values fold back by one deck length (52..63 -> 0..11).
            SAMPLE: p <= (rng_value >= RNG_WIDTH'(DECK_SIZE)) ?
                         rng_value - RNG_WIDTH'(DECK_SIZE) : rng_value;
            PROBE: begin
               if (used[p]) begin
                  p <= (p == RNG_WIDTH'(DECK_SIZE-1)) ? '0 : p + 1'b1;
               end else begin
                  used[p]     <= 1'b1;
                  cards_left  <= cards_left - 6'd1;
                  card_rank   <= dec_rank;
                  card_suit   <= dec_suit;
                  card_points <= dec_points;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: vector table, deck-model scoreboard for
// random full-deck dealing, and hand-written shuffle/reset corner cases.
module tb_card_dealer;
   logic       clk = 1'b0;
   logic       reset, shuffle, deal_req;
   logic [5:0] rng_value;
   logic       rng_request, card_valid, busy, deck_empty;
   logic [5:0] rng_max, cards_left;
   logic [3:0] card_rank, card_points;
   logic [1:0] card_suit;

   card_dealer dut (
      .clk(clk), .reset(reset), .shuffle(shuffle), .deal_req(deal_req),
      .rng_value(rng_value), .rng_request(rng_request), .rng_max(rng_max),
      .card_valid(card_valid), .card_rank(card_rank), .card_suit(card_suit),
      .card_points(card_points), .busy(busy), .deck_empty(deck_empty),
      .cards_left(cards_left)
   );

   always #5 clk = ~clk;

   typedef struct {int rank; int suit; int pts; int lat; int left;} exp_t;
   typedef struct {logic [5:0] rng; exp_t e;} vec_t;

   exp_t      sb[$];
   vec_t      tbl[11];
   bit [51:0] mdl_used;
   bit [51:0] seen;
   int        nchk = 0;
   int        nerr = 0;

   task automatic check(input string name, input int act, input int exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input int rank, input int suit, input int lat, input int left);
      exp_t e;
      e.rank = rank; e.suit = suit; e.pts = (rank >= 10) ? 10 : rank;
      e.lat = lat; e.left = left;
      return e;
   endfunction

   // Reference deck: fold, then forward probe with wrap over the bench's own mask.
   function automatic exp_t model(input logic [5:0] rng, input int left_after);
      int p, k;
      p = (int'(rng) >= 52) ? int'(rng) - 52 : int'(rng);
      k = 0;
      while (mdl_used[p] && k < 52) begin
         p = (p + 1) % 52;
         k++;
      end
      return mk(p % 13 + 1, p / 13, 4 + k, left_after);
   endfunction

   task automatic deal(input logic [5:0] rng, input exp_t e, input int shuf_at);
      int lat, idx;
      exp_t g;
      sb.push_back(e);
      @(negedge clk); rng_value = rng; deal_req = 1'b1;
      @(negedge clk); deal_req = 1'b0;
      check("rng_request", int'(rng_request), 1);
      check("busy_in_deal", int'(busy), 1);
      lat = 1;
      shuffle = (lat == shuf_at);
      while (!card_valid && lat < 80) begin
         @(negedge clk);
         lat++;
         shuffle = (lat == shuf_at);
      end
      shuffle = 1'b0;
      g = sb.pop_front();
      if (!card_valid) begin
         nchk++; nerr++;
         $display("FAIL card_valid_timeout: no strobe after %0d cycles, expected at %0d", lat, g.lat);
      end else begin
         check("card_rank", int'(card_rank), g.rank);
         check("card_suit", int'(card_suit), g.suit);
         check("card_points", int'(card_points), g.pts);
         check("latency", lat, g.lat);
         check("cards_left", int'(cards_left), g.left);
         idx = 13 * int'(card_suit) + int'(card_rank) - 1;
         if (idx >= 0 && idx < 52) seen[idx] = 1'b1;
      end
      mdl_used[g.suit*13 + g.rank - 1] = 1'b1;
   endtask

   initial begin
      int   bad;
      exp_t e;
      reset = 1'b1; shuffle = 1'b0; deal_req = 1'b0; rng_value = '0;
      mdl_used = '0; seen = '0;

      // vectors for a fresh deck: wrap, skips, fold of 52..63, long probe run
      tbl[0]  = '{6'd51, mk(13, 3, 4, 51)};
      tbl[1]  = '{6'd51, mk(1, 0, 5, 50)};
      tbl[2]  = '{6'd10, mk(11, 0, 4, 49)};
      tbl[3]  = '{6'd10, mk(12, 0, 5, 48)};
      tbl[4]  = '{6'd60, mk(9, 0, 4, 47)};
      tbl[5]  = '{6'd63, mk(13, 0, 5, 46)};
      tbl[6]  = '{6'd25, mk(13, 1, 4, 45)};
      tbl[7]  = '{6'd26, mk(1, 2, 4, 44)};
      tbl[8]  = '{6'd52, mk(2, 0, 5, 43)};
      tbl[9]  = '{6'd8,  mk(10, 0, 5, 42)};
      tbl[10] = '{6'd9,  mk(1, 1, 8, 41)};

      #12;
      check("rst_card_valid", int'(card_valid), 0);
      check("rst_rank", int'(card_rank), 0);
      check("rst_suit", int'(card_suit), 0);
      check("rst_points", int'(card_points), 0);
      check("rst_rng_request", int'(rng_request), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_deck_empty", int'(deck_empty), 0);
      check("rst_cards_left", int'(cards_left), 52);
      check("rng_max", int'(rng_max), 51);
      @(negedge clk); reset = 1'b0;

      deal(6'd0, mk(1, 0, 4, 51), -1);

      @(negedge clk); shuffle = 1'b1;
      @(negedge clk); shuffle = 1'b0; mdl_used = '0;
      check("shuffle_idle_left", int'(cards_left), 52);

      for (int i = 0; i < 11; i++) deal(tbl[i].rng, tbl[i].e, -1);

      // full deck with random values against the model
      @(negedge clk); shuffle = 1'b1;
      @(negedge clk); shuffle = 1'b0; mdl_used = '0; seen = '0;
      for (int i = 0; i < 52; i++) begin
         logic [5:0] r;
         r = 6'($urandom_range(0, 63));
         e = model(r, 51 - i);
         deal(r, e, -1);
      end
      @(negedge clk);
      check("unique_cards", $countones(seen), 52);
      check("empty_left", int'(cards_left), 0);
      check("empty_flag", int'(deck_empty), 1);
      check("empty_busy", int'(busy), 0);
      deal_req = 1'b1;
      @(negedge clk); deal_req = 1'b0;
      bad = 0;
      repeat (6) begin
         if (rng_request || card_valid) bad = 1;
         @(negedge clk);
      end
      check("deal_when_empty", bad, 0);
      check("still_empty", int'(deck_empty), 1);

      shuffle = 1'b1;
      @(negedge clk); shuffle = 1'b0; mdl_used = '0;
      check("shuffle_empty_left", int'(cards_left), 52);
      check("shuffle_empty_flag", int'(deck_empty), 0);

      // shuffle while probing: card delivered, then deck restored
      deal(6'd0, model(6'd0, 51), -1);
      deal(6'd0, model(6'd0, 50), 3);
      @(negedge clk); mdl_used = '0;
      check("shuffle_probe_left", int'(cards_left), 52);
      check("shuffle_probe_empty", int'(deck_empty), 0);

      // shuffle and deal together in IDLE: deal dropped
      shuffle = 1'b1; deal_req = 1'b1; rng_value = 6'd3;
      @(negedge clk); shuffle = 1'b0; deal_req = 1'b0;
      bad = 0;
      repeat (4) begin
         if (rng_request || busy) bad = 1;
         @(negedge clk);
      end
      check("shuffle_wins", bad, 0);

      // async reset in the middle of a probe run
      deal(6'd0, model(6'd0, 51), -1);
      deal(6'd1, model(6'd1, 50), -1);
      deal(6'd2, model(6'd2, 49), -1);
      @(negedge clk); rng_value = 6'd0; deal_req = 1'b1;
      @(negedge clk); deal_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("pre_reset_busy", int'(busy), 1);
      #2 reset = 1'b1;
      #1;
      check("arst_rank", int'(card_rank), 0);
      check("arst_points", int'(card_points), 0);
      check("arst_busy", int'(busy), 0);
      check("arst_left", int'(cards_left), 52);
      check("arst_valid", int'(card_valid), 0);
      @(negedge clk); reset = 1'b0; mdl_used = '0;
      deal(6'd5, model(6'd5, 51), -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
      $finish;
   end
endmodule

// File: doc/card_dealer.md
Name: card_dealer

Overview:
- Consumer end of the random-number request interface: draws cards without replacement from a 52-card deck for the blackjack game FSM.
- On a deal request it pulses a request to the random number generator and samples the returned value. It maps the value to a card not yet dealt, using a forward linear probe. It then returns rank, suit and blackjack points with a one-cycle valid strobe.
- Sits between the game FSM (player/dealer hand logic) and randomNumberGenerator.

Parameters:
- DECK_SIZE, 52, number of distinct cards; index 0..DECK_SIZE-1.
- RNG_WIDTH, 6, width of the random value bus; must satisfy 2**RNG_WIDTH >= DECK_SIZE.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- shuffle  input  1  pulse: return all cards to the deck.
- deal_req  input  1  pulse: request one card; ignored unless state is IDLE.
- rng_value  input  RNG_WIDTH  random value from the generator.
- rng_request  output  1  one-cycle request to the generator.
- rng_max  output  RNG_WIDTH  constant DECK_SIZE-1 (51).
- card_valid  output  1  one-cycle strobe; card fields valid this cycle.
- card_rank  output  4  1=Ace .. 13=King.
- card_suit  output  2  0=clubs, 1=diamonds, 2=hearts, 3=spades.
- card_points  output  4  Ace=1, 2..10 face value, J/Q/K=10.
- busy  output  1  high in any state other than IDLE and EMPTY.
- deck_empty  output  1  high when cards_left==0.
- cards_left  output  6  undealt card count.

Behaviour:
- Reset (async, any state):
  - state=IDLE, used mask all 0, cards_left=52.
  - card_valid=0, card_rank=0, card_suit=0, card_points=0, rng_request=0.
  - busy=0, deck_empty=0.
- Card index i maps to suit=i/13 and rank=(i mod 13)+1.
- States:
  - IDLE: deal_req & cards_left>0 -> REQUEST. deal_req & cards_left==0 -> EMPTY.
  - REQUEST: rng_request=1 for exactly one cycle -> SAMPLE.
  - SAMPLE: latch rng_value into probe index p. If rng_value>=52, p=rng_value-52 (so 52..63 map to 0..11). -> PROBE.
  - PROBE: one mask lookup per cycle.
    - used[p]==0: set used[p], decrement cards_left, load card fields -> DONE.
    - used[p]==1: p = (p==51) ? 0 : p+1, then stay in PROBE.
    - Wrap 51->0 is mandatory. Termination is guaranteed because cards_left>0 was checked in IDLE. Worst case is 52 probe cycles.
  - DONE: card_valid=1 for one cycle -> IDLE (or EMPTY if cards_left==0).
  - EMPTY: deck_empty=1. deal_req is ignored with no card_valid. shuffle -> IDLE.
- Latency: deal_req in cycle N gives rng_request in N+1, sample in N+2, first probe in N+3, and card_valid at N+4+k, where k = number of used slots skipped (0..51).
- card_rank, card_suit and card_points hold their last dealt values until the next DONE.
- shuffle:
  - In IDLE or EMPTY: clears the mask, sets cards_left=52, state goes to IDLE next cycle.
  - In REQUEST, SAMPLE, PROBE or DONE: shuffle is latched as pending and applied on return to IDLE. The in-flight card completes and is counted against the old deck, then the clear takes effect.
- shuffle & deal_req in the same IDLE cycle: shuffle wins and deal_req is dropped. The FSM must re-request.
- deal_req while busy: ignored, not queued.
- rng_value is sampled only in SAMPLE. Values held by the generator between requests are irrelevant.
- Arithmetic: cards_left never underflows. The decrement happens only on a successful probe.

Decomposition:
- Package card_pkg:
  - DECK_SIZE, SUIT_SIZE=13.
  - suit_t enum, rank_t (4-bit).
  - dealer_state_t enum {IDLE, REQUEST, SAMPLE, PROBE, DONE, EMPTY}.
  - function card_points_f(rank_t) returning 4-bit points.
- Sub-module card_decode: combinational index (0..51) -> rank, suit, points. The hand-display logic reuses it.

Test Plan:
- Reset, then deal_req with rng_value=0 -> rng_request at N+1; card_valid at N+4 with rank=1, suit=0, points=1; cards_left=51.
- Deal index 10, then deal_req with rng_value=10 -> probe skips one slot; card_valid at N+5 with rank=12, suit=0, points=10.
- Pre-deal index 51, then deal_req with rng_value=51 -> wraps to 0; card_valid with rank=1, suit=0. Also: deal_req with rng_value=60 on a fresh deck -> index 8, rank=9, suit=0.
- 52 consecutive deals with random rng_value -> all 52 (suit, rank) pairs unique, cards_left=0, deck_empty=1. A 53rd deal_req -> no card_valid and no rng_request.
- shuffle asserted during PROBE -> the current card is delivered; the next cycle in IDLE shows cards_left=52 and deck_empty=0. shuffle & deal_req together in IDLE -> no rng_request.
- reset asserted mid-PROBE, asynchronously between clock edges -> outputs zero immediately, cards_left=52, busy=0.
